// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per
// clock, LSB chunk first, carrying between chunks through a register so the
// combinational carry chain is only CHUNK bits long. Valid/ready on both sides,
// one operation in flight at a time.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_addsub: WIDTH must be >= 1 and an exact multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [IW-1:0]    bitBase;
  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK:0]   chunkSum;
  logic             msbCarryIn;
  logic             lastChunk;

  // Slice out the current chunk and add it; the carry into the top bit of the
  // chunk is recovered from sum ^ a ^ b, which also works when CHUNK is 1.
  always_comb begin
    bitBase    = IW'(cnt_q * CHUNK);
    chunkA     = opA_q[bitBase +: CHUNK];
    chunkB     = opB_q[bitBase +: CHUNK];
    chunkSum   = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, carry_q};
    msbCarryIn = chunkSum[CHUNK-1] ^ chunkA[CHUNK-1] ^ chunkB[CHUNK-1];
    lastChunk  = (cnt_q == CW'(NCHUNK - 1));
  end

  // Next-state logic: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        sum_d[bitBase +: CHUNK] = chunkSum[CHUNK-1:0];
        carry_d = chunkSum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (lastChunk) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = chunkSum[CHUNK];
          ovf_d   = msbCarryIn ^ chunkSum[CHUNK];
          zero_d  = (sum_d == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three instances (CHUNK = 4, 16, 1, all WIDTH = 16)
// share operands, clock and reset but have their own handshake signals.
// Results are checked against an integer-arithmetic reference model.
module tb_chunked_addsub;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        inValid  [3];
  logic        outReady [3];
  logic        inReady  [3];
  logic        outValid [3];
  logic [15:0] sumO     [3];
  logic        coutO    [3];
  logic        ovfO     [3];
  logic        zeroO    [3];

  int nCompared;
  int nMismatched;

  localparam int EXP_LAT [3] = '{4, 1, 16};

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .sum(sumO[0]), .cout(coutO[0]), .ovf(ovfO[0]),
    .zero(zeroO[0])
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .sum(sumO[1]), .cout(coutO[1]), .ovf(ovfO[1]),
    .zero(zeroO[1])
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .sum(sumO[2]), .cout(coutO[2]), .ovf(ovfO[2]),
    .zero(zeroO[2])
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain unsigned/signed integer arithmetic
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic co,
                                output logic ov, output logic z);
    int ua, ub, c, sa, sbv, sr;
    ua  = int'(av);
    ub  = int'(bv);
    c   = ci ? 1 : 0;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    if (!sb) begin
      co = (ua + ub + c) > 65535;
      s  = 16'(ua + ub + c);
      sr = sa + sbv + c;
    end else begin
      co = (ua >= ub + c);
      s  = 16'(ua - ub - c);
      sr = sa - sbv - c;
    end
    ov = (sr > 32767) || (sr < -32768);
    z  = (s == 16'h0000);
  endfunction

  // Present operands for one accept edge, then scramble them to show they are ignored
  task automatic startOp(input int idx, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb;
    inValid[idx] = 1'b1;
    @(negedge clk);
    inValid[idx] = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Count cycles from the accept edge until out_valid, bounded
  task automatic waitDone(input int idx, output int lat);
    lat = 0;
    while (outValid[idx] !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the result handshake at the current negedge
  task automatic handshake(input int idx);
    outReady[idx] = 1'b1;
    @(negedge clk);
    outReady[idx] = 1'b0;
  endtask

  // Run one full operation on an instance and compare everything to the model
  task automatic runAndCheck(input int idx, input logic [15:0] av, input logic [15:0] bv,
                             input logic ci, input logic sb);
    logic [15:0] es;
    logic eco, eov, ez;
    int lat;
    model(av, bv, ci, sb, es, eco, eov, ez);
    startOp(idx, av, bv, ci, sb);
    nCompared++;
    if (sumO[idx] !== 16'h0000) begin
      nMismatched++;
      $display("[TB] FAIL clear_on_accept[%0d] sum=%h want 0000", idx, sumO[idx]);
    end
    waitDone(idx, lat);
    nCompared++;
    if (lat !== EXP_LAT[idx]) begin
      nMismatched++;
      $display("[TB] FAIL latency[%0d] got %0d want %0d", idx, lat, EXP_LAT[idx]);
    end
    nCompared++;
    if ({sumO[idx], coutO[idx], ovfO[idx], zeroO[idx]} !== {es, eco, eov, ez}) begin
      nMismatched++;
      $display("[TB] FAIL result[%0d] a=%h b=%h cin=%b sub=%b got s=%h c=%b o=%b z=%b want s=%h c=%b o=%b z=%b",
               idx, av, bv, ci, sb, sumO[idx], coutO[idx], ovfO[idx], zeroO[idx], es, eco, eov, ez);
    end
    if (outValid[idx] === 1'b1) handshake(idx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if ({inReady[i], outValid[i], sumO[i], coutO[i], ovfO[i], zeroO[i]} !== {2'b10, 16'h0, 3'b000}) begin
        nMismatched++;
        $display("[TB] FAIL reset_state[%0d] rdy=%b vld=%b s=%h c=%b o=%b z=%b want rdy=1 vld=0 s=0000 flags=0",
                 i, inReady[i], outValid[i], sumO[i], coutO[i], ovfO[i], zeroO[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] da [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
    logic [15:0] db [4] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007};
    logic        ds [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ws [4] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE};
    logic [2:0]  wf [4] = '{3'b000, 3'b101, 3'b010, 3'b000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      startOp(0, da[i], db[i], 1'b0, ds[i]);
      waitDone(0, lat);
      nCompared++;
      if (lat !== 4) begin
        nMismatched++;
        $display("[TB] FAIL directed_latency[%0d] got %0d want 4", i, lat);
      end
      nCompared++;
      if ({sumO[0], coutO[0], ovfO[0], zeroO[0]} !== {ws[i], wf[i]}) begin
        nMismatched++;
        $display("[TB] FAIL directed[%0d] got s=%h cfz=%b%b%b want s=%h cfz=%b",
                 i, sumO[0], coutO[0], ovfO[0], zeroO[0], ws[i], wf[i]);
      end
      if (outValid[0] === 1'b1) handshake(0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      runAndCheck(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] es1, es2, a2, b2;
    logic c1, o1, z1, c2, o2, z2;
    int lat;
    model(16'hABCD, 16'h1111, 1'b1, 1'b1, es1, c1, o1, z1);
    startOp(0, 16'hABCD, 16'h1111, 1'b1, 1'b1);
    waitDone(0, lat);
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    model(a2, b2, 1'b1, 1'b0, es2, c2, o2, z2);
    a = a2; b = b2; cin = 1'b1; sub = 1'b0;
    inValid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nCompared++;
      if ({outValid[0], inReady[0], sumO[0], coutO[0], ovfO[0], zeroO[0]} !== {2'b10, es1, c1, o1, z1}) begin
        nMismatched++;
        $display("[TB] FAIL hold[%0d] vld=%b rdy=%b s=%h want vld=1 rdy=0 s=%h",
                 i, outValid[0], inReady[0], sumO[0], es1);
      end
    end
    handshake(0);
    nCompared++;
    if ({outValid[0], inReady[0], sumO[0], coutO[0], ovfO[0], zeroO[0]} !== {2'b01, es1, c1, o1, z1}) begin
      nMismatched++;
      $display("[TB] FAIL after_handshake vld=%b rdy=%b s=%h want vld=0 rdy=1 s=%h",
               outValid[0], inReady[0], sumO[0], es1);
    end
    @(negedge clk);
    inValid[0] = 1'b0;
    nCompared++;
    if ({inReady[0], sumO[0]} !== {1'b0, 16'h0000}) begin
      nMismatched++;
      $display("[TB] FAIL reaccept rdy=%b s=%h want rdy=0 s=0000", inReady[0], sumO[0]);
    end
    waitDone(0, lat);
    nCompared++;
    if (lat !== 4 || {sumO[0], coutO[0], ovfO[0], zeroO[0]} !== {es2, c2, o2, z2}) begin
      nMismatched++;
      $display("[TB] FAIL second_result lat=%0d s=%h want lat=4 s=%h", lat, sumO[0], es2);
    end
    if (outValid[0] === 1'b1) handshake(0);
  endtask

  task automatic test_reset_midrun();
    startOp(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if (sumO[0] !== 16'h0055) begin
      nMismatched++;
      $display("[TB] FAIL partial_sum got %h want 0055", sumO[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({outValid[0], inReady[0], sumO[0]} !== {2'b01, 16'h0000}) begin
      nMismatched++;
      $display("[TB] FAIL midrun_reset vld=%b rdy=%b s=%h want vld=0 rdy=1 s=0000",
               outValid[0], inReady[0], sumO[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runAndCheck(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0);
  endtask

  task automatic test_chunk_variants();
    for (int idx = 1; idx < 3; idx++) begin
      runAndCheck(idx, 16'h1234, 16'h4321, 1'b0, 1'b0);
      nCompared++;
      if (sumO[idx] !== 16'h5555) begin
        nMismatched++;
        $display("[TB] FAIL variant_sum[%0d] got %h want 5555", idx, sumO[idx]);
      end
      runAndCheck(idx, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        runAndCheck(idx, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
    end
  endtask

  // Test sequence
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b0;
    end
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_chunk_variants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
